// File: rtl/xrv_dmem_resp.sv
// xrv_dmem_resp: data-memory responder for the xrv core's load/store port.
//
// Accepts one read or write request at a time, waits WAIT_CYCLES extra
// cycles, then pulses the matching ready for one cycle. Storage is a
// word-addressed array with byte-enable writes and a side preload port.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   d_addr[31:0]              byte address (bits [1:0] ignored)
//   d_wr_req / d_wr_ready     write request / one-cycle completion pulse
//   d_rd_req / d_rd_ready     read request / one-cycle data-valid pulse
//   d_be[3:0], d_wr_data[31:0] write byte enables and data
//   d_rd_data[31:0]           read data (holds until the next read response)
//   ld_en, ld_addr, ld_data   preload word write, any FSM state
//   err                       out-of-range flag, pulses with ready
//
// state  | meaning
// -------+-----------------------------------------------
// S_IDLE | waiting for a request; inputs sampled here only
// S_WAIT | counting down the programmed wait states
// S_RESP | ready pulse; write commits / read data shown

module xrv_dmem_resp #(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              d_addr,
    input  logic                     d_wr_req,
    output logic                     d_wr_ready,
    input  logic                     d_rd_req,
    output logic                     d_rd_ready,
    input  logic [3:0]               d_be,
    input  logic [31:0]              d_wr_data,
    output logic [31:0]              d_rd_data,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [31:0]              ld_data,
    output logic                     err
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [32:0] SPAN      = 33'(DEPTH) << 2;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state, state_nxt;
    logic [3:0]    wait_cnt;
    logic [AW-1:0] idx_q;
    logic          in_range_q;
    logic          is_wr_q;
    logic [3:0]    be_q;
    logic [31:0]   wr_data_q;
    logic [31:0]   rd_data_q;
    logic [31:0]   rd_word;
    logic [31:0]   offset;
    logic          in_range;
    logic          accept;
    logic          wr_commit;

    logic [31:0]   mem [DEPTH];

    // Offset is unsigned: addresses below BASE_ADDR wrap to large values
    // and fall out of range naturally.
    assign offset   = d_addr - BASE_ADDR;
    assign in_range = {1'b0, offset} < SPAN;
    assign accept   = (state == S_IDLE) && (d_wr_req || d_rd_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            rd_data_q <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept)
                wait_cnt <= WAIT_LOAD;
            else if (state == S_WAIT && wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;
            if (state == S_RESP && !is_wr_q)
                rd_data_q <= rd_word;
        end
    end

    // Write wins when both requests are high; the read stays pending.
    always_ff @(posedge clk) begin
        if (accept) begin
            is_wr_q    <= d_wr_req;
            idx_q      <= offset[AW+1:2];
            in_range_q <= in_range;
            be_q       <= d_be;
            wr_data_q  <= d_wr_data;
        end
    end

    always_comb begin
        state_nxt  = state;
        d_wr_ready = 1'b0;
        d_rd_ready = 1'b0;
        err        = 1'b0;
        rd_word    = in_range_q ? mem[idx_q] : 32'd0;
        case (state)
            S_IDLE: begin
                if (d_wr_req || d_rd_req)
                    state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0)
                    state_nxt = S_RESP;
            end
            S_RESP: begin
                state_nxt = S_IDLE;
                // A reset landing on the response cycle abandons the access.
                if (!rst) begin
                    d_wr_ready = is_wr_q;
                    d_rd_ready = !is_wr_q;
                    err        = !in_range_q;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        d_rd_data = d_rd_ready ? rd_word : rd_data_q;
    end

    assign wr_commit = (state == S_RESP) && is_wr_q && in_range_q && !rst;

    // Preload is written last so it overrides any core bytes on the same word.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b])
                    mem[idx_q][8*b +: 8] <= wr_data_q[8*b +: 8];
            end
        end
        if (ld_en)
            mem[ld_addr] <= ld_data;
    end

endmodule

// File: tb/tb_xrv_dmem_resp.sv
module tb_xrv_dmem_resp;

    localparam int DEPTH = 1024;
    localparam int W     = 2;
    localparam int LIMIT = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] d_addr;
    logic        d_wr_req;
    logic        d_wr_ready;
    logic        d_rd_req;
    logic        d_rd_ready;
    logic [3:0]  d_be;
    logic [31:0] d_wr_data;
    logic [31:0] d_rd_data;
    logic        ld_en;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;
    logic        err;

    typedef struct {
        logic        is_wr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    int          n_chk = 0;
    int          n_err = 0;

    xrv_dmem_resp #(
        .DEPTH(DEPTH),
        .WAIT_CYCLES(W),
        .BASE_ADDR(32'h0000_0000)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .d_addr(d_addr),
        .d_wr_req(d_wr_req),
        .d_wr_ready(d_wr_ready),
        .d_rd_req(d_rd_req),
        .d_rd_ready(d_rd_ready),
        .d_be(d_be),
        .d_wr_data(d_wr_data),
        .d_rd_data(d_rd_data),
        .ld_en(ld_en),
        .ld_addr(ld_addr),
        .ld_data(ld_data),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Response monitor: every ready pops one scoreboard entry.
    always @(negedge clk) begin
        exp_t e;
        check_val("both_ready", 32'(d_rd_ready & d_wr_ready), 32'd0);
        if (d_rd_ready || d_wr_ready) begin
            if (sb.size() == 0) begin
                check_val("unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check_val("resp_kind_wr", 32'(d_wr_ready), 32'(e.is_wr));
                check_val("resp_err", 32'(err), 32'(e.err));
                if (!e.is_wr)
                    check_val("rd_data", d_rd_data, e.data);
            end
        end else begin
            check_val("err_without_ready", 32'(err), 32'd0);
        end
    end

    task automatic preload(input int idx, input logic [31:0] val);
        ld_en   = 1'b1;
        ld_addr = 10'(idx);
        ld_data = val;
        model[idx] = val;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic wait_ready(input logic want_wr, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!(want_wr ? d_wr_ready : d_rd_ready) && cnt < LIMIT);
        if (cnt >= LIMIT)
            check_val("ready_timeout", 32'd0, 32'd1);
    endtask

    // One access from an IDLE negedge; optionally fires a preload into the
    // same word during the response cycle.
    task automatic access(input logic is_wr, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wdata, input logic ld_hit, input logic [31:0] ld_val);
        exp_t e;
        int   cnt;
        int   idx;
        logic inr;
        idx = int'(addr[11:2]);
        inr = addr < 32'(DEPTH * 4);
        e.is_wr = is_wr;
        e.err   = !inr;
        e.data  = (!is_wr && inr) ? model[idx] : 32'd0;
        sb.push_back(e);
        if (is_wr && inr) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) model[idx][8*b +: 8] = wdata[8*b +: 8];
        end
        d_addr    = addr;
        d_be      = be;
        d_wr_data = wdata;
        d_wr_req  = is_wr;
        d_rd_req  = !is_wr;
        wait_ready(is_wr, cnt);
        check_val(is_wr ? "wr_latency" : "rd_latency", 32'(cnt), 32'(W + 1));
        d_wr_req = 1'b0;
        d_rd_req = 1'b0;
        if (ld_hit) begin
            ld_en   = 1'b1;
            ld_addr = 10'(idx);
            ld_data = ld_val;
            model[idx] = ld_val;
        end
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   cnt;
        rst = 1'b1;
        d_addr = '0; d_wr_req = 1'b0; d_rd_req = 1'b0;
        d_be = '0; d_wr_data = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (3) @(negedge clk);
        check_val("rst_wr_ready", 32'(d_wr_ready), 32'd0);
        check_val("rst_rd_ready", 32'(d_rd_ready), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_rd_data", d_rd_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic round trip and hold of read data.
        preload(3, 32'hDEADBEEF);
        access(1'b0, 32'hC, 4'h0, 32'h0, 1'b0, 32'h0);
        check_val("rd_hold", d_rd_data, 32'hDEADBEEF);
        repeat (2) @(negedge clk);
        check_val("rd_hold_later", d_rd_data, 32'hDEADBEEF);

        // Byte-enable write.
        preload(0, 32'h11223344);
        access(1'b1, 32'h0, 4'b0101, 32'hAABBCCDD, 1'b0, 32'h0);
        access(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0);
        check_val("be_merge", d_rd_data, 32'h11BB33DD);

        // Range boundary and out-of-range accesses.
        preload(DEPTH - 1, 32'hCAFEF00D);
        access(1'b0, 32'hFFC, 4'h0, 32'h0, 1'b0, 32'h0);
        access(1'b0, 32'h1000, 4'h0, 32'h0, 1'b0, 32'h0);
        access(1'b1, 32'h1000, 4'hF, 32'hFFFFFFFF, 1'b0, 32'h0);
        access(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'h0);
        check_val("oor_word0_kept", d_rd_data, 32'h11BB33DD);

        // Simultaneous requests: write first, read accepted on the next IDLE.
        e.is_wr = 1'b1; e.err = 1'b0; e.data = 32'h0;
        sb.push_back(e);
        e.is_wr = 1'b0; e.data = 32'h5A5A5A5A;
        sb.push_back(e);
        model[5] = 32'h5A5A5A5A;
        d_addr = 32'h14; d_be = 4'hF; d_wr_data = 32'h5A5A5A5A;
        d_wr_req = 1'b1; d_rd_req = 1'b1;
        wait_ready(1'b1, cnt);
        check_val("simul_wr_latency", 32'(cnt), 32'(W + 1));
        d_wr_req = 1'b0;
        wait_ready(1'b0, cnt);
        check_val("simul_rd_latency", 32'(cnt), 32'(W + 2));
        d_rd_req = 1'b0;
        @(negedge clk);

        // Reset during WAIT abandons the write.
        preload(7, 32'h0);
        d_addr = 32'h1C; d_be = 4'hF; d_wr_data = 32'hFFFFFFFF; d_wr_req = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        d_wr_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check_val("midrst_rd_data", d_rd_data, 32'd0);
        repeat (W + 2) @(negedge clk);
        access(1'b0, 32'h1C, 4'h0, 32'h0, 1'b0, 32'h0);
        check_val("midrst_word7", d_rd_data, 32'h0);

        // Preload collisions with a write and with a read response.
        preload(9, 32'h0);
        access(1'b1, 32'h24, 4'hF, 32'h0BADF00D, 1'b1, 32'h12345678);
        access(1'b0, 32'h24, 4'h0, 32'h0, 1'b1, 32'h87654321);
        check_val("ld_rd_old", d_rd_data, 32'h12345678);
        access(1'b0, 32'h24, 4'h0, 32'h0, 1'b0, 32'h0);
        check_val("ld_rd_new", d_rd_data, 32'h87654321);

        // Zero byte enables: completes, no change.
        access(1'b1, 32'h24, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h0);
        access(1'b0, 32'h24, 4'h0, 32'h0, 1'b0, 32'h0);

        repeat (2) @(negedge clk);
        check_val("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
